// File: rtl/intpol_lin_nch_fifo.sv
// N-channel linear interpolator (factor 2^l) fed from a shared FWFT FIFO.
// One FSM steps all channels in lockstep; output issue stalls on downstream almost-full.
module intpol_lin_nch_fifo #(
    parameter int DW        = 32,
    parameter int NCH       = 2,
    parameter int LOG2_LMAX = 3,
    parameter int FIFO_AW   = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 start,
    input  logic                 cfg_bypass,
    input  logic [LOG2_LMAX-1:0] cfg_log2_l,
    input  logic [31:0]          cfg_nsamp,
    input  logic                 in_valid,
    input  logic [NCH*DW-1:0]    in_data,
    output logic                 in_afull,
    output logic                 in_ovf,
    input  logic                 out_afull_i,
    output logic                 out_valid,
    output logic [NCH*DW-1:0]    out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 stop_empty,
    output logic                 stop_afull
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int AW    = DW + LOG2_LMAX + 1;
    localparam int LW    = $clog2(LOG2_LMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_INTERP, S_LAST, S_DONE} state_t;

    function automatic logic signed [AW-1:0] ext_x(input logic signed [DW-1:0] v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] ext_d(input logic signed [DW:0] v);
        return {{(AW-DW-1){v[DW]}}, v};
    endfunction

    function automatic logic signed [DW:0] diff(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
        return {a[DW-1], a} - {b[DW-1], b};
    endfunction

    // Arithmetic shift gives floor division; the result always lies between x0 and x1.
    function automatic logic signed [DW-1:0] floor_shift(input logic signed [AW-1:0] acc,
                                                         input logic [LW-1:0] l);
        logic signed [AW-1:0] t;
        t = acc >>> l;
        return t[DW-1:0];
    endfunction

    state_t                 r_state;
    logic [NCH*DW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0]     r_wp, r_rp;
    logic [FIFO_AW:0]       r_cnt;
    logic                   r_byp;
    logic [LW-1:0]          r_l;
    logic [31:0]            r_rem;
    logic [LOG2_LMAX-1:0]   r_k;
    logic signed [DW-1:0]   r_x0  [NCH];
    logic signed [DW-1:0]   r_x1  [NCH];
    logic signed [AW-1:0]   r_acc [NCH];
    logic signed [DW:0]     r_d   [NCH];

    logic                   w_empty, w_full, w_wr, w_pop, w_issue, w_more, w_k_last;
    logic                   w_stall_e, w_stall_a;
    logic [NCH*DW-1:0]      w_head, w_odata;
    logic [LW-1:0]          w_cfg_l;
    logic [LOG2_LMAX-1:0]   w_lmask;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == (FIFO_AW+1)'(DEPTH));
    assign w_head     = r_mem[r_rp];
    assign w_wr       = in_valid && (!w_full || w_pop);
    assign in_afull   = (r_cnt >= (FIFO_AW+1)'(DEPTH - AF_MARGIN));
    assign w_cfg_l    = (int'(cfg_log2_l) > LOG2_LMAX) ? LW'(LOG2_LMAX) : LW'(cfg_log2_l);
    assign w_lmask    = LOG2_LMAX'((1 << r_l) - 1);
    assign w_k_last   = (r_k == w_lmask);
    assign w_more     = r_byp && (r_rem != 32'd0);
    assign stop_empty = w_stall_e;
    assign stop_afull = w_stall_a;

    always_comb begin
        w_pop     = 1'b0;
        w_issue   = 1'b0;
        w_stall_e = 1'b0;
        w_stall_a = 1'b0;
        case (r_state)
            S_LOAD, S_FETCH: begin
                if (w_empty) w_stall_e = 1'b1;
                else         w_pop     = 1'b1;
            end
            S_INTERP: begin
                if (out_afull_i) w_stall_a = 1'b1;
                else             w_issue   = 1'b1;
            end
            // Bypass streams by issuing x0 and refilling it in the same cycle.
            S_LAST: begin
                if (out_afull_i)           w_stall_a = 1'b1;
                else if (w_more && w_empty) w_stall_e = 1'b1;
                else begin
                    w_issue = 1'b1;
                    w_pop   = w_more;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_odata = '0;
        for (int c = 0; c < NCH; c++)
            w_odata[c*DW +: DW] = (r_state == S_LAST) ? r_x0[c] : floor_shift(r_acc[c], r_l);
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= in_data;
        for (int c = 0; c < NCH; c++) begin
            if ((r_state == S_LOAD || r_state == S_LAST) && w_pop)
                r_x0[c] <= w_head[c*DW +: DW];
            if (r_state == S_FETCH && w_pop) begin
                r_x1[c]  <= w_head[c*DW +: DW];
                r_acc[c] <= ext_x(r_x0[c]) <<< r_l;
                r_d[c]   <= diff(w_head[c*DW +: DW], r_x0[c]);
            end
            if (r_state == S_INTERP && w_issue) begin
                r_acc[c] <= r_acc[c] + ext_d(r_d[c]);
                if (w_k_last) r_x0[c] <= r_x1[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state   <= S_IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_byp     <= 1'b0;
            r_l       <= '0;
            r_rem     <= '0;
            r_k       <= '0;
            in_ovf    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_valid <= w_issue;
            if (w_issue) out_data <= w_odata;
            if (w_wr)    r_wp <= r_wp + 1'b1;
            if (w_pop)   r_rp <= r_rp + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            if (in_valid && !w_wr) in_ovf <= 1'b1;

            case (r_state)
                S_IDLE: if (start) begin
                    r_byp   <= cfg_bypass || (w_cfg_l == '0);
                    r_l     <= w_cfg_l;
                    r_rem   <= cfg_nsamp - 32'd1;
                    in_ovf  <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= (cfg_nsamp == 32'd0) ? S_DONE : S_LOAD;
                end
                S_LOAD: if (w_pop)
                    r_state <= (r_byp || r_rem == 32'd0) ? S_LAST : S_FETCH;
                S_FETCH: if (w_pop) begin
                    r_k     <= '0;
                    r_state <= S_INTERP;
                end
                S_INTERP: if (w_issue) begin
                    r_k <= r_k + 1'b1;
                    if (w_k_last) begin
                        r_rem   <= r_rem - 32'd1;
                        r_state <= (r_rem == 32'd1) ? S_LAST : S_FETCH;
                    end
                end
                S_LAST: if (w_issue) begin
                    if (w_more) r_rem   <= r_rem - 32'd1;
                    else        r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intpol_lin_nch_fifo.sv
// Scoreboard bench: a floor-division reference model fills an expected queue,
// a negedge monitor pops and compares on every out_valid.
module tb_intpol_lin_nch_fifo;
    localparam int DW = 32, NCH = 2, LMAX = 3;

    logic              clk = 1'b0, rst_a = 1'b0, start = 1'b0, cfg_bypass = 1'b0;
    logic [LMAX-1:0]   cfg_log2_l = '0;
    logic [31:0]       cfg_nsamp = '0;
    logic              in_valid = 1'b0, out_afull_i = 1'b0;
    logic [NCH*DW-1:0] in_data = '0;
    logic              in_afull, in_ovf, out_valid, busy, done, stop_empty, stop_afull;
    logic [NCH*DW-1:0] out_data;

    intpol_lin_nch_fifo #(.DW(DW), .NCH(NCH), .LOG2_LMAX(LMAX), .FIFO_AW(3), .AF_MARGIN(2)) dut (
        .clk(clk), .rst_a(rst_a), .start(start), .cfg_bypass(cfg_bypass),
        .cfg_log2_l(cfg_log2_l), .cfg_nsamp(cfg_nsamp), .in_valid(in_valid),
        .in_data(in_data), .in_afull(in_afull), .in_ovf(in_ovf), .out_afull_i(out_afull_i),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done),
        .stop_empty(stop_empty), .stop_afull(stop_afull));

    always #5 clk = ~clk;

    logic [63:0] stim_q[$];
    logic [63:0] exp_q[$];
    int n_checks = 0, n_fail = 0, se_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a && out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", {64'd0, out_data}, 128'hDEAD);
            else chk("out_data", {64'd0, out_data}, {64'd0, exp_q.pop_front()});
        end
    end

    function automatic logic [63:0] pack(input int a, input int b);
        return {b[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] rnd_word();
        logic [63:0] w;
        if ($urandom_range(0, 1) == 1) w = {$urandom(), $urandom()};
        else w = pack($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200);
        return w;
    endfunction

    // Expected outputs straight from the interpolation formula: floor((x0*L + k*(x1-x0)) / L).
    function automatic void model(input bit byp, input int l);
        int le, n, ll;
        longint a, b, v, q;
        logic [63:0] wa, wb, ew;
        le = (l > LMAX) ? LMAX : l;
        ll = 1 << le;
        n  = stim_q.size();
        if (n == 0) return;
        if (byp || le == 0) begin
            foreach (stim_q[i]) exp_q.push_back(stim_q[i]);
            return;
        end
        for (int i = 0; i < n - 1; i++) begin
            wa = stim_q[i];
            wb = stim_q[i+1];
            for (int k = 0; k < ll; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    a = longint'($signed(wa[c*32 +: 32]));
                    b = longint'($signed(wb[c*32 +: 32]));
                    v = a * ll + k * (b - a);
                    q = v / ll;
                    if (v % ll != 0 && v < 0) q = q - 1;
                    ew[c*32 +: 32] = q[31:0];
                end
                exp_q.push_back(ew);
            end
        end
        exp_q.push_back(stim_q[n-1]);
    endfunction

    task automatic feed(input int gap);
        int t;
        foreach (stim_q[i]) begin
            t = 0;
            while (in_afull && t < 4000) begin @(negedge clk); t++; end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic run(input bit byp, input int l, input int gap, input bit rnd_af, input bit hold);
        bit fin = 1'b0, got_done = 1'b0;
        int cyc = 0;
        model(byp, l);
        se_cnt = 0;
        @(negedge clk);
        cfg_bypass = byp;
        cfg_log2_l = LMAX'(l);
        cfg_nsamp  = stim_q.size();
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cfg_bypass = 1'($urandom);
        cfg_log2_l = LMAX'($urandom);
        cfg_nsamp  = $urandom;
        chk("busy_after_start", busy, 1);
        fork
            if (gap >= 0) feed(gap);
            begin
                while (!fin) begin
                    @(negedge clk);
                    if (rnd_af) out_afull_i = ($urandom_range(0, 3) == 0);
                end
                out_afull_i = 1'b0;
            end
            begin
                while (!done && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if (stop_empty) se_cnt++;
                end
                got_done = done;
                fin = 1'b1;
            end
            if (hold) begin
                int t = 0;
                while (!out_valid && t < 2000) begin @(negedge clk); t++; end
                chk("hold_saw_output", out_valid, 1);
                out_afull_i = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1 chk("stop_afull_held", stop_afull, 1);
                    @(negedge clk);
                    chk("no_valid_while_afull", out_valid, 0);
                end
                out_afull_i = 1'b0;
            end
        join
        chk("done_seen", got_done, 1);
        chk("busy_low_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("outputs_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic set_stim(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(rnd_word());
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ow [9];
        #2;
        chk("reset_outputs", {out_valid, busy, done, in_afull, in_ovf, stop_empty, stop_afull, out_data},
            71'd0);
        @(negedge clk);
        rst_a = 1'b1;

        stim_q = '{pack(0, 0), pack(8, -8), pack(16, -16)};
        run(0, 2, 0, 0, 0);
        stim_q = '{pack(5, -5), pack(6, -6), pack(7, -7), pack(8, -8)};
        run(1, 2, 0, 1, 0);
        stim_q = '{pack(3, 32'h7FFFFFFF), pack(-4, 32'h80000000)};
        run(0, 1, 1, 0, 0);
        set_stim(6);
        run(0, 3, 0, 0, 1);
        for (int r = 0; r < 6; r++) begin
            set_stim($urandom_range(1, 7));
            run(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3), 1, 0);
        end
        set_stim(4);
        run(0, 2, 5, 0, 0);
        chk("stop_empty_seen", se_cnt > 0, 1);
        chk("no_ovf_normal", in_ovf, 0);

        for (int i = 0; i < 9; i++) ow[i] = rnd_word();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = ow[i];
            @(negedge clk);
            if (i == 4) chk("afull_at_5", in_afull, 0);
            if (i == 5) chk("afull_at_6", in_afull, 1);
            if (i == 7) chk("ovf_before_drop", in_ovf, 0);
        end
        in_valid = 1'b0;
        chk("ovf_after_drop", in_ovf, 1);
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(ow[i]);
        run(1, 0, -1, 0, 0);
        chk("ovf_cleared_by_start", in_ovf, 0);

        set_stim(4);
        foreach (stim_q[i]) begin
            in_valid = 1'b1;
            in_data  = stim_q[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        model(0, 2);
        cfg_bypass = 1'b0; cfg_log2_l = 3'd2; cfg_nsamp = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int t = 0;
            while (!out_valid && t < 200) begin @(negedge clk); t++; end
            chk("t6_running", out_valid, 1);
        end
        @(negedge clk);
        rst_a = 1'b0;
        #1 chk("async_reset_outputs",
               {out_valid, busy, done, in_afull, in_ovf, stop_empty, stop_afull, out_data}, 71'd0);
        exp_q.delete();
        stim_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        cfg_nsamp = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nsamp0_done_not_yet", done, 0);
        @(negedge clk);
        chk("nsamp0_done", done, 1);
        chk("nsamp0_busy_low", busy, 0);
        @(negedge clk);
        chk("nsamp0_done_pulse", done, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
